mod_counter: RTL and testbench

MOD_COUNTER -- requirements
Module: mod_counter

---
 rtl/counter_pkg.sv | 15 +
 rtl/tick_prescaler.sv | 33 +++
 rtl/mod_counter.sv | 101 ++++++++++
 tb/tb_mod_counter.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/counter_pkg.sv
// Shared definitions for the modulo counter: direction encodings and the
// parameter legality check used at elaboration.
package counter_pkg;

   localparam logic DIR_UP = 1'b1;
   localparam logic DIR_DN = 1'b0;

   // The modulus must fit the count register and leave at least two states.
   function automatic bit params_legal(input int width, input int modv, input int prescale);
      longint span;
      span = longint'(1) << width;
      return (modv >= 2) && (longint'(modv) <= span) && (prescale >= 1);
   endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Enable-gated prescaler: asserts tick on every PRESCALE-th enabled cycle.
// Phase is held as a down-count of enabled cycles remaining before the tick.
module tick_prescaler
   import counter_pkg::*;
#(
   parameter int PRESCALE = 1
) (
   input  logic clk,
   input  logic reset,
   input  logic en,
   input  logic sync_clr,
   output logic tick
);

   localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam logic [PW-1:0] RELOAD = PW'(PRESCALE - 1);

   logic [PW-1:0] r_remain;

   // Terminal count reached with PRESCALE=1 means tick simply follows en.
   assign tick = en & (r_remain == '0);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_remain <= RELOAD;
      end else if (sync_clr) begin
         r_remain <= RELOAD;
      end else if (en) begin
         r_remain <= tick ? RELOAD : (r_remain - 1'b1);
      end
   end

endmodule

// File: rtl/mod_counter.sv
// Prescaled up/down modulo counter with wrap or saturate at the ends of
// 0..MOD-1, a one-cycle terminal-count pulse and a sticky overflow flag.
module mod_counter
   import counter_pkg::*;
#(
   parameter int WIDTH    = 8,
   parameter int MOD      = 200,
   parameter int PRESCALE = 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             en,
   input  logic             up_dn,
   input  logic             sat_mode,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   input  logic             clear_ovf,
   output logic [WIDTH-1:0] count,
   output logic             tc,
   output logic             ovf
);

   generate
      if (!params_legal(WIDTH, MOD, PRESCALE)) begin : g_bad_params
         $error("mod_counter: illegal WIDTH/MOD/PRESCALE combination");
      end
   endgenerate

   // The top count value always fits WIDTH bits, so every compare stays in WIDTH bits.
   localparam logic [WIDTH-1:0] MAXV = WIDTH'(MOD - 1);

   logic [WIDTH-1:0] r_count;
   logic             r_tc;
   logic             r_ovf;

   logic             w_tick;
   logic             w_step;
   logic             w_bound;
   logic             w_ovf_set;
   logic [WIDTH-1:0] w_next;

   tick_prescaler #(
      .PRESCALE (PRESCALE)
   ) u_prescaler (
      .clk      (clk),
      .reset    (reset),
      .en       (en),
      .sync_clr (load),
      .tick     (w_tick)
   );

   always_comb begin
      w_step    = en & ~load & w_tick;
      w_next    = r_count;
      w_bound   = 1'b0;
      w_ovf_set = 1'b0;
      if (load) begin
         if (load_val > MAXV) begin
            w_next    = MAXV;
            w_ovf_set = 1'b1;
         end else begin
            w_next = load_val;
         end
      end else if (w_step) begin
         if (up_dn == DIR_UP) begin
            if (r_count == MAXV) begin
               w_bound = 1'b1;
               w_next  = sat_mode ? MAXV : '0;
            end else begin
               w_next = r_count + 1'b1;
            end
         end else begin
            if (r_count == '0) begin
               w_bound = 1'b1;
               w_next  = sat_mode ? '0 : MAXV;
            end else begin
               w_next = r_count - 1'b1;
            end
         end
      end
      w_ovf_set = w_ovf_set | w_bound;
   end

   // A set event in the same cycle as clear_ovf keeps the flag high.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_count <= '0;
         r_tc    <= 1'b0;
         r_ovf   <= 1'b0;
      end else begin
         r_count <= w_next;
         r_tc    <= w_bound;
         r_ovf   <= w_ovf_set | (r_ovf & ~clear_ovf);
      end
   end

   assign count = r_count;
   assign tc    = r_tc;
   assign ovf   = r_ovf;

endmodule

// File: tb/tb_mod_counter.sv
// Self-checking bench for mod_counter: a default instance checked against a
// reference model through an expectation queue, plus a PRESCALE=4 instance.
module tb_mod_counter;

   localparam int MODV = 200;

   typedef struct {
      int unsigned count;
      bit          tc;
      bit          ovf;
   } exp_t;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       en = 1'b0, up_dn = 1'b1, sat_mode = 1'b0, load = 1'b0, clear_ovf = 1'b0;
   logic [7:0] load_val = '0;
   logic [7:0] count;
   logic       tc, ovf;

   logic       reset4 = 1'b1;
   logic       en4 = 1'b0, load4 = 1'b0;
   logic [7:0] count4;
   logic       tc4, ovf4;

   int n_checks = 0;
   int n_errors = 0;

   int m_count = 0;
   bit m_tc = 1'b0;
   bit m_ovf = 1'b0;

   exp_t sb_q[$];

   always #5 clk = ~clk;

   mod_counter dut (
      .clk(clk), .reset(reset), .en(en), .up_dn(up_dn), .sat_mode(sat_mode),
      .load(load), .load_val(load_val), .clear_ovf(clear_ovf),
      .count(count), .tc(tc), .ovf(ovf)
   );

   mod_counter #(.WIDTH(8), .MOD(MODV), .PRESCALE(4)) dut_p4 (
      .clk(clk), .reset(reset4), .en(en4), .up_dn(1'b1), .sat_mode(1'b0),
      .load(load4), .load_val(8'd0), .clear_ovf(1'b0),
      .count(count4), .tc(tc4), .ovf(ovf4)
   );

   task automatic chk(input string tag, input int unsigned got, input int unsigned exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got %0d expected %0d at %0t", tag, got, exp, $time);
      end
   endtask

   // Reference model for one edge at PRESCALE=1 (tick equals en).
   task automatic drive(input bit e, input bit u, input bit s, input bit ld,
                        input int lv, input bit cl);
      exp_t x;
      exp_t y;
      bit   set;
      en = e; up_dn = u; sat_mode = s; load = ld; load_val = 8'(lv); clear_ovf = cl;
      set  = 1'b0;
      m_tc = 1'b0;
      if (ld) begin
         if (lv >= MODV) begin
            m_count = MODV - 1;
            set     = 1'b1;
         end else begin
            m_count = lv;
         end
      end else if (e) begin
         if (u) begin
            if (m_count == MODV - 1) begin
               set = 1'b1; m_tc = 1'b1;
               m_count = s ? MODV - 1 : 0;
            end else m_count = m_count + 1;
         end else begin
            if (m_count == 0) begin
               set = 1'b1; m_tc = 1'b1;
               m_count = s ? 0 : MODV - 1;
            end else m_count = m_count - 1;
         end
      end
      m_ovf = set | (m_ovf & ~cl);
      x.count = m_count; x.tc = m_tc; x.ovf = m_ovf;
      sb_q.push_back(x);
      @(posedge clk);
      #1;
      if (sb_q.size() == 0) begin
         chk("sb_empty", 1, 0);
      end else begin
         y = sb_q.pop_front();
         chk("count", count, y.count);
         chk("tc", tc, y.tc);
         chk("ovf", ovf, y.ovf);
      end
   endtask

   task automatic p4_cycle(input bit e);
      en4 = e;
      @(posedge clk);
      #1;
   endtask

   initial begin
      #2;
      chk("rst_count", count, 0);
      chk("rst_tc", tc, 0);
      chk("rst_ovf", ovf, 0);
      @(posedge clk);
      #1;
      reset = 1'b0;

      // Free-run up with wrap across the MOD-1 boundary.
      for (int i = 0; i < 201; i++) begin
         drive(1, 1, 0, 0, 0, 0);
         if (i == 198) chk("up_top", count, 199);
         if (i == 199) begin
            chk("wrap_count", count, 0);
            chk("wrap_tc", tc, 1);
            chk("wrap_ovf", ovf, 1);
         end
      end
      drive(0, 1, 0, 0, 0, 1);
      chk("clr_ovf", ovf, 0);

      // Saturating up from 198: one normal step, then held boundary steps.
      drive(0, 1, 1, 1, 198, 0);
      for (int i = 0; i < 4; i++) begin
         drive(1, 1, 1, 0, 0, 0);
         if (i >= 1) chk("sat_tc", tc, 1);
      end
      chk("sat_hold", count, 199);
      chk("sat_ovf", ovf, 1);

      // Down wrap from 0, then boundary set racing clear_ovf.
      drive(0, 0, 0, 1, 0, 1);
      chk("load0_clr", ovf, 0);
      drive(1, 0, 0, 0, 0, 0);
      chk("dn_wrap", count, 199);
      chk("dn_tc", tc, 1);
      drive(0, 0, 0, 1, 0, 1);
      drive(1, 0, 0, 0, 0, 1);
      chk("set_beats_clr", ovf, 1);

      // Out-of-range load clamps; load beats a concurrent step.
      drive(0, 0, 0, 1, 0, 1);
      drive(0, 1, 0, 1, 250, 0);
      chk("clamp_count", count, 199);
      chk("clamp_ovf", ovf, 1);
      chk("clamp_tc", tc, 0);
      drive(1, 1, 0, 1, 5, 0);
      chk("load_vs_step", count, 5);
      drive(1, 0, 1, 1, 0, 0);
      drive(1, 0, 1, 0, 0, 0);
      chk("dn_sat_hold", count, 0);

      for (int i = 0; i < 80; i++) begin
         drive(($urandom_range(0, 3) != 0), $urandom_range(0, 1), $urandom_range(0, 1),
               ($urandom_range(0, 7) == 0), $urandom_range(0, 255),
               ($urandom_range(0, 7) == 0));
      end

      // Async reset between edges while a tc pulse is active.
      drive(0, 1, 0, 1, 199, 0);
      drive(1, 1, 0, 1, 199, 0);
      drive(1, 1, 0, 0, 0, 0);
      #2;
      reset = 1'b1;
      #1;
      chk("async_count", count, 0);
      chk("async_tc", tc, 0);
      chk("async_ovf", ovf, 0);
      #1;
      reset = 1'b0;
      m_count = 0; m_tc = 1'b0; m_ovf = 1'b0;
      drive(1, 1, 0, 0, 0, 0);

      // PRESCALE=4: enable pattern 1,1,0,1,1 gives one step on the 4th enabled cycle.
      reset4 = 1'b0;
      p4_cycle(1); chk("p4_e1", count4, 0);
      p4_cycle(1); chk("p4_e2", count4, 0);
      p4_cycle(0); chk("p4_off", count4, 0);
      p4_cycle(1); chk("p4_e3", count4, 0);
      p4_cycle(1); chk("p4_e4", count4, 1);
      p4_cycle(1);
      p4_cycle(1);
      #2;
      reset4 = 1'b1;
      #1;
      chk("p4_async", count4, 0);
      #1;
      reset4 = 1'b0;
      for (int i = 0; i < 3; i++) begin
         p4_cycle(1);
         chk("p4_fresh", count4, 0);
      end
      p4_cycle(1);
      chk("p4_full", count4, 1);
      chk("p4_tc", tc4, 0);
      load4 = 1'b1;
      p4_cycle(1);
      load4 = 1'b0;
      chk("p4_load", count4, 0);
      for (int i = 0; i < 3; i++) p4_cycle(1);
      chk("p4_load_phase", count4, 0);
      p4_cycle(1);
      chk("p4_after_load", count4, 1);
      chk("p4_ovf", ovf4, 0);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
